// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the TPU control path: sequencer state
// encoding, layer-index width and the default layer count.
package tpu_ctrl_pkg;

    localparam int LAYER_IDX_W        = 3;
    localparam int NUM_LAYERS_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BLK,
        COMPUTE,
        NEXT_CH,
        NEXT_SP,
        LAYER_END
    } seq_state_t;

endpackage

// File: rtl/extraction_sequencer.sv
// Per-inference control FSM driving the patch extraction buffer and PE array.
// Optional wait-state watchdog is built only when SEQ_WATCHDOG_EN is defined.
module extraction_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS      = NUM_LAYERS_DEFAULT,
    parameter int BLK_CNT_W       = 16,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_inference,
    input  logic                   abort,
    output logic [LAYER_IDX_W-1:0] current_layer_idx,
    output logic                   start_extraction,
    output logic                   next_channel_group,
    output logic                   next_spatial_block,
    input  logic                   block_ready,
    input  logic                   extraction_complete,
    input  logic                   all_channels_done,
    output logic                   compute_start,
    input  logic                   compute_done,
    output logic                   layer_done,
    output logic                   inference_done,
    output logic                   busy,
    output logic [BLK_CNT_W-1:0]   blocks_done,
    output logic                   error
);

    localparam logic [LAYER_IDX_W-1:0] LAST_LAYER = LAYER_IDX_W'(NUM_LAYERS - 1);

    if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || WATCHDOG_CYCLES < 2) begin : g_bad_params
        $error("extraction_sequencer: parameter out of range");
    end

    seq_state_t             state_reg, state_next;
    logic [LAYER_IDX_W-1:0] layer_reg, layer_next;
    logic [BLK_CNT_W-1:0]   blocks_reg, blocks_next;
    logic                   ach_reg, ach_next;
    logic                   ec_reg, ec_next;
    logic                   guard_reg, guard_next;
    logic                   wd_timeout;

    logic start_extraction_reg, compute_start_reg, next_ch_reg, next_sp_reg;
    logic layer_done_reg, inference_done_reg, busy_reg;

    always_comb begin
        state_next  = state_reg;
        layer_next  = layer_reg;
        blocks_next = blocks_reg;
        ach_next    = ach_reg;
        ec_next     = ec_reg;
        guard_next  = 1'b0;

        if (abort) begin
            state_next = IDLE;
            layer_next = '0;
        end else if (wd_timeout) begin
            state_next = IDLE;
            layer_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_inference) begin
                        layer_next  = '0;
                        blocks_next = '0;
                        state_next  = START;
                    end
                end
                START: begin
                    state_next = WAIT_BLK;
                    guard_next = 1'b1;
                end
                WAIT_BLK: begin
                    // First cycle after a buffer request lets a stale ready drop.
                    if (!guard_reg && block_ready) begin
                        ach_next   = all_channels_done;
                        ec_next    = extraction_complete;
                        state_next = COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (compute_done) begin
                        if (blocks_reg != '1) begin
                            blocks_next = blocks_reg + 1'b1;
                        end
                        if (!ach_reg) begin
                            state_next = NEXT_CH;
                        end else if (!ec_reg) begin
                            state_next = NEXT_SP;
                        end else begin
                            state_next = LAYER_END;
                        end
                    end
                end
                NEXT_CH, NEXT_SP: begin
                    state_next = WAIT_BLK;
                    guard_next = 1'b1;
                end
                LAYER_END: begin
                    if (layer_reg == LAST_LAYER) begin
                        layer_next = '0;
                        state_next = IDLE;
                    end else begin
                        layer_next  = layer_reg + 1'b1;
                        blocks_next = '0;
                        state_next  = START;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Pulses are decoded from the next state so each lasts exactly the one
    // cycle spent in its single-cycle state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= IDLE;
            layer_reg            <= '0;
            blocks_reg           <= '0;
            ach_reg              <= 1'b0;
            ec_reg               <= 1'b0;
            guard_reg            <= 1'b0;
            start_extraction_reg <= 1'b0;
            compute_start_reg    <= 1'b0;
            next_ch_reg          <= 1'b0;
            next_sp_reg          <= 1'b0;
            layer_done_reg       <= 1'b0;
            inference_done_reg   <= 1'b0;
            busy_reg             <= 1'b0;
        end else begin
            state_reg            <= state_next;
            layer_reg            <= layer_next;
            blocks_reg           <= blocks_next;
            ach_reg              <= ach_next;
            ec_reg               <= ec_next;
            guard_reg            <= guard_next;
            start_extraction_reg <= (state_next == START);
            compute_start_reg    <= (state_next == COMPUTE) && (state_reg == WAIT_BLK);
            next_ch_reg          <= (state_next == NEXT_CH);
            next_sp_reg          <= (state_next == NEXT_SP);
            layer_done_reg       <= (state_next == LAYER_END);
            inference_done_reg   <= (state_next == LAYER_END) && (layer_next == LAST_LAYER);
            busy_reg             <= (state_next != IDLE);
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            error_reg;
    logic            in_wait;

    assign in_wait    = (state_reg == WAIT_BLK) || (state_reg == COMPUTE);
    assign wd_timeout = in_wait && (wd_cnt_reg == WD_W'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            if (!in_wait || (state_next != state_reg)) begin
                wd_cnt_reg <= '0;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (!abort && wd_timeout) begin
                error_reg <= 1'b1;
            end else if (!abort && (state_reg == IDLE) && start_inference) begin
                error_reg <= 1'b0;
            end
        end
    end

    assign error = error_reg;
`else
    assign wd_timeout = 1'b0;
    assign error      = 1'b0;
`endif

    assign current_layer_idx  = layer_reg;
    assign blocks_done        = blocks_reg;
    assign start_extraction   = start_extraction_reg;
    assign compute_start      = compute_start_reg;
    assign next_channel_group = next_ch_reg;
    assign next_spatial_block = next_sp_reg;
    assign layer_done         = layer_done_reg;
    assign inference_done     = inference_done_reg;
    assign busy               = busy_reg;

endmodule

// File: tb/tb_extraction_sequencer.sv
// Randomized bench for extraction_sequencer: a buffer/PE environment reacts to
// the DUT, and the observed pulse stream is matched against a plan-derived model.
module tb_extraction_sequencer;

    localparam int NL  = 3;
    localparam int BW  = 3;
    localparam int WD  = 16;
    localparam int SAT = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          reset, start_inference, abort;
    logic [2:0]    current_layer_idx;
    logic          start_extraction, next_channel_group, next_spatial_block;
    logic          block_ready, extraction_complete, all_channels_done;
    logic          compute_start, compute_done, layer_done, inference_done, busy, error;
    logic [BW-1:0] blocks_done;

    always #5 clk = ~clk;

    extraction_sequencer #(
        .NUM_LAYERS      (NL),
        .BLK_CNT_W       (BW),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_inference     (start_inference),
        .abort               (abort),
        .current_layer_idx   (current_layer_idx),
        .start_extraction    (start_extraction),
        .next_channel_group  (next_channel_group),
        .next_spatial_block  (next_spatial_block),
        .block_ready         (block_ready),
        .extraction_complete (extraction_complete),
        .all_channels_done   (all_channels_done),
        .compute_start       (compute_start),
        .compute_done        (compute_done),
        .layer_done          (layer_done),
        .inference_done      (inference_done),
        .busy                (busy),
        .blocks_done         (blocks_done),
        .error               (error)
    );

    // mask bits: [0] start_extraction [1] compute_start [2] next_ch
    //            [3] next_sp [4] layer_done [5] inference_done
    typedef struct {
        logic [5:0] mask;
        int         layer;
        int         blk;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  ch_n[NL];
    int  sp_n[NL];
    int  cyc = 0;

    bit env_active, waiting_blk, outstanding, hold_ready, no_ready, stray_en;
    bit start_req, abort_req, abort_armed, aborted;
    int env_layer, cur_ch, cur_sp, ready_wait, done_wait;
    int abort_layer, held_blk, last_pulse_cyc;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int sat(int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic ev_t mk(logic [5:0] m, int l, int b);
        ev_t e;
        e.mask  = m;
        e.layer = l;
        e.blk   = b;
        return e;
    endfunction

    // Expected pulse stream: channel groups iterate inside spatial blocks.
    task automatic build_expected();
        exp_q.delete();
        for (int l = 0; l < NL; l++) begin
            int b;
            b = 0;
            exp_q.push_back(mk(6'b000001, l, 0));
            for (int s = 0; s < sp_n[l]; s++) begin
                for (int c = 0; c < ch_n[l]; c++) begin
                    exp_q.push_back(mk(6'b000010, l, sat(b)));
                    b++;
                    if (c < ch_n[l] - 1)
                        exp_q.push_back(mk(6'b000100, l, sat(b)));
                    else if (s < sp_n[l] - 1)
                        exp_q.push_back(mk(6'b001000, l, sat(b)));
                    else
                        exp_q.push_back(mk((l == NL - 1) ? 6'b110000 : 6'b010000, l, sat(b)));
                end
            end
        end
    endtask

    task automatic observe();
        logic [5:0] mask;
        ev_t        e;
        e    = mk(6'b0, 0, 0);
        mask = {inference_done, layer_done, next_spatial_block,
                next_channel_group, compute_start, start_extraction};
        if (mask != 6'b0) begin
            if (exp_q.size() == 0) begin
                check("unexp_pulse", {26'd0, mask}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_mask", {26'd0, mask}, {26'd0, e.mask});
                check("layer_idx", {29'd0, current_layer_idx}, e.layer);
                check("blocks_done", {29'd0, blocks_done}, e.blk);
                check("busy_active", {31'd0, busy}, 32'd1);
            end
            if (start_extraction || next_channel_group || next_spatial_block) begin
                waiting_blk    = 1'b1;
                ready_wait     = $urandom_range(0, 3);
                last_pulse_cyc = cyc;
            end
            if (start_extraction) begin
                cur_ch = 0;
                cur_sp = 0;
            end
            if (next_channel_group) cur_ch++;
            if (next_spatial_block) begin
                cur_sp++;
                cur_ch = 0;
            end
            if (compute_start) begin
                check("guard_gap", {31'd0, (cyc - last_pulse_cyc) >= 3}, 32'd1);
                waiting_blk = 1'b0;
                outstanding = 1'b1;
                done_wait   = $urandom_range(1, 5);
                if (abort_armed && env_layer == abort_layer) begin
                    abort_req   = 1'b1;
                    abort_armed = 1'b0;
                    held_blk    = e.blk;
                    done_wait   = 1;
                end
            end
            if (layer_done) begin
                if (inference_done) env_active = 1'b0;
                else env_layer++;
            end
        end
    endtask

    task automatic drive();
        compute_done = 1'b0;
        if (outstanding) begin
            if (done_wait == 0) begin
                compute_done = 1'b1;
                outstanding  = 1'b0;
            end else begin
                done_wait--;
            end
        end else if (stray_en && $urandom_range(0, 7) == 0) begin
            compute_done = 1'b1;
        end

        if (no_ready) begin
            block_ready = 1'b0;
        end else if (hold_ready) begin
            block_ready = 1'b1;
        end else if (waiting_blk) begin
            if (ready_wait == 0) begin
                block_ready = 1'b1;
            end else begin
                ready_wait--;
                block_ready = 1'b0;
            end
        end else begin
            block_ready = stray_en && ($urandom_range(0, 3) == 0);
        end

        all_channels_done   = env_active && (cur_ch == ch_n[env_layer] - 1);
        extraction_complete = env_active && (cur_sp == sp_n[env_layer] - 1);
        start_inference     = start_req || (stray_en && env_active && $urandom_range(0, 15) == 0);
        start_req           = 1'b0;
        abort               = abort_req;
        if (abort_req) begin
            abort_req = 1'b0;
            aborted   = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        observe();
        drive();
    endtask

    task automatic begin_inference();
        build_expected();
        env_active  = 1'b1;
        env_layer   = 0;
        waiting_blk = 1'b0;
        outstanding = 1'b0;
        start_req   = 1'b1;
    endtask

    task automatic set_plan(int c0, int s0, int c1, int s1, int c2, int s2);
        ch_n[0] = c0; sp_n[0] = s0;
        ch_n[1] = c1; sp_n[1] = s1;
        ch_n[2] = c2; sp_n[2] = s2;
    endtask

    task automatic run_inference(string name);
        int n;
        n = 0;
        begin_inference();
        while (env_active && n < 3000) begin
            step();
            n++;
        end
        check("inference_bound", {31'd0, n < 3000}, 32'd1);
        step();
        check("busy_after", {31'd0, busy}, 32'd0);
        check("idx_after", {29'd0, current_layer_idx}, 32'd0);
        check("blocks_held", {29'd0, blocks_done}, sat(ch_n[NL-1] * sp_n[NL-1]));
        check("exp_left", exp_q.size(), 32'd0);
        check("error_low", {31'd0, error}, 32'd0);
        $display("run %-10s plan=%0dx%0d/%0dx%0d/%0dx%0d hold=%0d cycles=%0d",
                 name, ch_n[0], sp_n[0], ch_n[1], sp_n[1], ch_n[2], sp_n[2], hold_ready, n);
    endtask

    initial begin
        reset = 1'b1;
        start_inference = 1'b0; abort = 1'b0; block_ready = 1'b0;
        extraction_complete = 1'b0; all_channels_done = 1'b0; compute_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_idx", {29'd0, current_layer_idx}, 32'd0);
        check("rst_blocks", {29'd0, blocks_done}, 32'd0);
        check("rst_pulses", {26'd0, start_extraction, compute_start, next_channel_group,
                             next_spatial_block, layer_done, inference_done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;

        set_plan(1, 1, 1, 1, 1, 1);
        run_inference("single");
        set_plan(2, 3, 1, 1, 1, 1);
        run_inference("ch2xsp3");
        set_plan(1, 2, 3, 4, 2, 1);
        run_inference("saturate");
        hold_ready = 1'b1;
        set_plan(2, 3, 2, 1, 1, 2);
        run_inference("hold_rdy");
        hold_ready = 1'b0;

        // Abort in COMPUTE of layer 1; compute_done lands the following cycle.
        set_plan(2, 2, 2, 2, 2, 2);
        abort_armed = 1'b1;
        abort_layer = 1;
        aborted     = 1'b0;
        begin_inference();
        for (int n = 0; n < 3000 && !aborted; n++) step();
        check("abort_reached", {31'd0, aborted}, 32'd1);
        exp_q.delete();
        env_active  = 1'b0;
        waiting_blk = 1'b0;
        step();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_idx", {29'd0, current_layer_idx}, 32'd0);
        check("abort_blocks", {29'd0, blocks_done}, held_blk);
        repeat (4) step();
        check("abort_done_ign", {29'd0, blocks_done}, held_blk);
        $display("run abort      layer=%0d held_blocks=%0d", abort_layer, held_blk);

        start_req = 1'b1;
        abort_req = 1'b1;
        step();
        step();
        check("abort_start_idle", {31'd0, busy}, 32'd0);
        repeat (3) step();
        $display("run abort+start in idle");
        set_plan(1, 2, 2, 1, 1, 1);
        run_inference("restart");

        // Reset in the middle of an inference.
        set_plan(2, 2, 2, 2, 2, 2);
        begin_inference();
        repeat (12) step();
        reset = 1'b1;
        exp_q.delete();
        env_active = 1'b0; waiting_blk = 1'b0; outstanding = 1'b0;
        step();
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_blocks", {29'd0, blocks_done}, 32'd0);
        check("midrst_idx", {29'd0, current_layer_idx}, 32'd0);
        $display("run mid-reset");

`ifdef SEQ_WATCHDOG_EN
        begin
            int t0;
            set_plan(1, 1, 1, 1, 1, 1);
            no_ready = 1'b1;
            begin_inference();
            t0 = -1;
            for (int n = 0; n < 10 && t0 < 0; n++) begin
                step();
                if (start_extraction) t0 = cyc;
            end
            check("wd_started", {31'd0, t0 >= 0}, 32'd1);
            while (cyc < t0 + 15) step();
            check("wd_err_early", {31'd0, error}, 32'd0);
            check("wd_busy_early", {31'd0, busy}, 32'd1);
            while (cyc < t0 + 18) step();
            check("wd_err_set", {31'd0, error}, 32'd1);
            check("wd_busy_idle", {31'd0, busy}, 32'd0);
            exp_q.delete();
            env_active = 1'b0;
            no_ready   = 1'b0;
            repeat (2) step();
            $display("run watchdog   start_cycle=%0d", t0);
        end
`endif

        stray_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            set_plan($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 3),
                     $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 4));
            hold_ready = ($urandom_range(0, 2) == 0);
            run_inference("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
